// File: rtl/xor_resp_checker_if.sv
// Sample stream from the vector source into the XOR response checker.
// The master drives a/b/c with valid; the slave answers with ready.
interface xor_resp_checker_if #(
  parameter int unsigned W = 4
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_c;

  modport master (
    output in_valid, in_a, in_b, in_c,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c,
    output in_ready
  );
endinterface

// File: rtl/xor_resp_checker.sv
// Scores an XOR-gate candidate: counts bit mismatches of c against a^b over NUM_VEC
// accepted samples, with a saturating error count and a held pass/done result.
module xor_resp_checker #(
  parameter int unsigned W       = 4,
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  xor_resp_checker_if.slave  in_if,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [15:0]        vec_count_o
);

  localparam int unsigned ErrW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [15:0]      vec_q, vec_d;
  logic [W-1:0]     diff;
  logic [ErrW-1:0]  errs;
  logic [CNT_W:0]   err_sum;
  logic             fire;

  assign diff = (in_if.in_a ^ in_if.in_b) ^ in_if.in_c;

  // Only a definite 0 is a match; an X bit falls through to the error branch in simulation.
  always_comb begin
    errs = '0;
    for (int i = 0; i < W; i++) begin
      if (diff[i] == 1'b0) begin
      end else begin
        errs = errs + ErrW'(1);
      end
    end
  end

  assign err_sum = {1'b0, err_q} + (CNT_W + 1)'(errs);
  assign fire    = (state_q == StRun) && in_if.in_valid;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StRun;
          err_d   = '0;
          vec_d   = '0;
        end
      end
      StRun: begin
        if (fire) begin
          err_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          vec_d = vec_q + 16'd1;
          if (vec_q == 16'(NUM_VEC - 1)) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
    end
  end

  assign in_if.in_ready = (state_q == StRun);
  assign busy_o         = (state_q == StRun);
  assign done_o         = (state_q == StDone);
  assign pass_o         = done_o && (err_q == '0);
  assign err_count_o    = err_q;
  assign vec_count_o    = vec_q;

endmodule

// File: tb/tb_xor_resp_checker.sv
// Directed bench for xor_resp_checker: table-driven run plus hand-written
// sequences for reset, gaps, start collisions and counter saturation.
module tb_xor_resp_checker;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  logic start, start_s;
  logic busy, done, pass;
  logic [15:0] err_count, vec_count;
  logic busy_s, done_s, pass_s;
  logic [2:0]  err_s;
  logic [15:0] vec_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xor_resp_checker_if #(.W(W)) bus ();
  xor_resp_checker_if #(.W(W)) bus_s ();

  xor_resp_checker #(.W(W), .NUM_VEC(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .in_if      (bus.slave),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .err_count_o(err_count),
    .vec_count_o(vec_count)
  );

  xor_resp_checker #(.W(W), .NUM_VEC(4), .CNT_W(3)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_s),
    .in_if      (bus_s.slave),
    .busy_o     (busy_s),
    .done_o     (done_s),
    .pass_o     (pass_s),
    .err_count_o(err_s),
    .vec_count_o(vec_s)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    int         exp_err;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " pass"}, pass, 0);
    check({tag, " ready"}, bus.in_ready, 0);
    check({tag, " err"}, err_count, 0);
    check({tag, " vec"}, vec_count, 0);
  endtask

  initial begin
    int exp;
    tbl[0]  = '{4'h0, 4'h0, 4'h0, 0};
    tbl[1]  = '{4'h1, 4'h2, 4'h3, 0};
    tbl[2]  = '{4'h5, 4'h3, 4'h6, 0};
    tbl[3]  = '{4'hF, 4'hF, 4'h0, 0};
    tbl[4]  = '{4'hA, 4'h5, 4'hF, 0};
    tbl[5]  = '{4'h8, 4'h1, 4'h9, 0};
    tbl[6]  = '{4'h7, 4'h7, 4'h1, 1};
    tbl[7]  = '{4'hC, 4'h3, 4'hF, 1};
    tbl[8]  = '{4'h2, 4'h4, 4'h6, 1};
    tbl[9]  = '{4'h9, 4'h6, 4'h0, 5};
    tbl[10] = '{4'h3, 4'h3, 4'h0, 5};
    tbl[11] = '{4'hE, 4'h1, 4'hE, 6};
    tbl[12] = '{4'h4, 4'h4, 4'h0, 6};
    tbl[13] = '{4'h6, 4'h9, 4'hF, 6};
    tbl[14] = '{4'hB, 4'hB, 4'h3, 8};
    tbl[15] = '{4'h1, 4'h0, 4'h1, 8};

    rst = 1'b1;
    start = 1'b0;
    start_s = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus_s.in_valid = 1'b0;
    bus_s.in_a = '0;
    bus_s.in_b = '0;
    bus_s.in_c = '0;
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // valid while idle must be ignored
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("idle valid vec", vec_count, 0);
    check("idle busy", busy, 0);

    // Table-driven run, gapless
    pulse_start();
    check("start busy", busy, 1);
    check("start ready", bus.in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].c);
      check($sformatf("tbl err[%0d]", i), err_count, tbl[i].exp_err);
      check($sformatf("tbl vec[%0d]", i), vec_count, i + 1);
    end
    check("tbl done", done, 1);
    check("tbl busy", busy, 0);
    check("tbl pass", pass, 0);
    check("tbl ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    bus.in_valid = 1'b0;
    check("done hold vec", vec_count, 16);
    check("done hold err", err_count, 8);
    check("done hold done", done, 1);

    // Perfect XOR; start collides with the final transfer
    pulse_start();
    check("restart done", done, 0);
    check("restart err", err_count, 0);
    check("restart vec", vec_count, 0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a, b;
      a = 4'(i);
      b = 4'((i * 5 + 3) & 15);
      if (i == 15) start = 1'b1;
      send(a, b, a ^ b);
      start = 1'b0;
    end
    check("perfect done", done, 1);
    check("perfect pass", pass, 1);
    check("perfect err", err_count, 0);
    check("perfect vec", vec_count, 16);
    tick();
    check("collide still done", done, 1);
    check("collide vec", vec_count, 16);

    // Stuck-at-0 response
    pulse_start();
    exp = 0;
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 4'h0, 4'h0);
      exp += $countones(4'(i));
      check($sformatf("stuck err[%0d]", i), err_count, exp);
    end
    check("stuck total", err_count, 32);
    check("stuck pass", pass, 0);
    check("stuck done", done, 1);

    // Gaps in valid plus start pulses mid-run
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 1) start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      send(tbl[i].a, tbl[i].b, tbl[i].c);
      check($sformatf("gap vec[%0d]", i), vec_count, i + 1);
    end
    check("gap err", err_count, 8);
    check("gap done", done, 1);
    check("gap pass", pass, 0);

    // Saturation on the CNT_W=3, NUM_VEC=4 instance
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    exp = 0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      a = 4'(i);
      bus_s.in_valid = 1'b1;
      bus_s.in_a = a;
      bus_s.in_b = 4'h3;
      bus_s.in_c = ~(a ^ 4'h3);
      tick();
      bus_s.in_valid = 1'b0;
      exp = (exp + 4 > 7) ? 7 : exp + 4;
      check($sformatf("sat err[%0d]", i), err_s, exp);
    end
    check("sat done", done_s, 1);
    check("sat vec", vec_s, 4);
    tick();
    tick();
    check("sat hold", err_s, 7);
    check("sat pass", pass_s, 0);

    // Asynchronous reset mid-cycle during a run
    pulse_start();
    for (int i = 0; i < 3; i++) send(tbl[i].a, tbl[i].b, tbl[i].c);
    check("pre-rst vec", vec_count, 3);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async rst");
    tick();
    rst = 1'b0;
    check_all_zero("post rst");

    // Reset after 5 vectors, then a full clean run
    pulse_start();
    for (int i = 0; i < 5; i++) send(tbl[i].a, tbl[i].b, tbl[i].c);
    check("abort vec", vec_count, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort rst vec", vec_count, 0);
    check("abort rst busy", busy, 0);
    tick();
    check("abort idle busy", busy, 0);
    pulse_start();
    check("clean start vec", vec_count, 0);
    for (int i = 0; i < 16; i++) begin
      send(4'(15 - i), 4'(i), 4'((15 - i) ^ i));
    end
    check("clean vec", vec_count, 16);
    check("clean pass", pass, 1);
    check("clean done", done, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
